// File: rtl/midori_rand_supply_if.sv
// -----------------------------------------------------------------------------
// midori_rand_supply_if
// Randomness-supply bus between the round controller side (master) and the
// randomness producer (slave, midori_rand_supply).
//   seed        master->slave  seed lanes {L2,L1,L0}, 64 bits each
//   seed_valid  master->slave  load seed this cycle
//   en          master->slave  request one fresh word
//   r           slave->master  randomness word {L2,L1,L0}
//   r_valid     slave->master  r is fresh this cycle
//   busy        slave->master  warm-up in progress
//   reseed_req  slave->master  no usable seed (idle or lifetime exhausted)
// -----------------------------------------------------------------------------
interface midori_rand_supply_if #(
    parameter int RW = 192
);
    logic [RW-1:0] seed;
    logic          seed_valid;
    logic          en;
    logic [RW-1:0] r;
    logic          r_valid;
    logic          busy;
    logic          reseed_req;

    modport master (
        output seed, seed_valid, en,
        input  r, r_valid, busy, reseed_req
    );

    modport slave (
        input  seed, seed_valid, en,
        output r, r_valid, busy, reseed_req
    );
endinterface

// File: rtl/midori_rand_supply.sv
// -----------------------------------------------------------------------------
// midori_rand_supply
// Fresh-randomness producer for the masked Midori S-box layer. A 192-bit seed
// is expanded by three 64-bit Fibonacci LFSR lanes (x^64+x^63+x^61+x^60+1),
// each advanced 64 steps per cycle. After every seed load WARMUP advances are
// discarded; afterwards one word is produced per enabled cycle until the
// 2^LIFE_W word lifetime runs out and a reseed is requested.
//
// Ports:
//   clk_i   clock, rising edge
//   rst_i   synchronous active-high reset
//   rnd     midori_rand_supply_if.slave (seed/seed_valid/en in,
//           r/r_valid/busy/reseed_req out, all outputs registered)
//
// State table:
//   IDLE    | no seed loaded; r=0, reseed_req=1
//   WARMUP  | lanes advance every cycle, output suppressed, busy=1
//   RUN     | en=1 advances lanes and presents one fresh word next cycle
//   EXHAUST | lifetime used up; lanes frozen, reseed_req=1
// -----------------------------------------------------------------------------
module midori_rand_supply #(
    parameter int RW     = 192,
    parameter int WARMUP = 16,
    parameter int LIFE_W = 20
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    midori_rand_supply_if.slave   rnd
);

    localparam int          LANE_W    = 64;
    localparam int          NLANE     = 3;
    localparam logic [63:0] ZERO_SUB  = 64'hA5A5_A5A5_A5A5_A5A5;
    localparam logic [7:0]  WARM_LAST = 8'(WARMUP - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WARMUP  = 2'd1,
        ST_RUN     = 2'd2,
        ST_EXHAUST = 2'd3
    } state_e;

    state_e              state_q;
    logic [RW-1:0]       lane_q;
    logic [RW-1:0]       r_q;
    logic                r_valid_q;
    logic                busy_q;
    logic                reseed_req_q;
    logic [7:0]          warm_q;
    logic [LIFE_W-1:0]   life_q;

    logic [RW-1:0]       adv_d;
    logic [RW-1:0]       load_d;

    // 64 single steps of the lane LFSR, unrolled into one combinational advance.
    function automatic logic [63:0] lfsr_advance(input logic [63:0] v);
        logic [63:0] s;
        s = v;
        for (int i = 0; i < LANE_W; i++) begin
            s = {s[62:0], s[63] ^ s[62] ^ s[60] ^ s[59]};
        end
        return s;
    endfunction

    // All-zero is the LFSR lock-up state, so a zero seed slice is substituted.
    always_comb begin
        adv_d  = '0;
        load_d = '0;
        for (int l = 0; l < NLANE; l++) begin
            adv_d[l*LANE_W +: LANE_W] = lfsr_advance(lane_q[l*LANE_W +: LANE_W]);
            if (rnd.seed[l*LANE_W +: LANE_W] == '0) begin
                load_d[l*LANE_W +: LANE_W] = ZERO_SUB;
            end else begin
                load_d[l*LANE_W +: LANE_W] = rnd.seed[l*LANE_W +: LANE_W];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            lane_q       <= '0;
            r_q          <= '0;
            r_valid_q    <= 1'b0;
            busy_q       <= 1'b0;
            reseed_req_q <= 1'b1;
            warm_q       <= '0;
            life_q       <= '0;
        end else if (rnd.seed_valid) begin
            // A load wins over en and discards everything in flight.
            state_q      <= ST_WARMUP;
            lane_q       <= load_d;
            r_q          <= '0;
            r_valid_q    <= 1'b0;
            busy_q       <= 1'b1;
            reseed_req_q <= 1'b0;
            warm_q       <= '0;
            life_q       <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    r_q       <= '0;
                    r_valid_q <= 1'b0;
                end
                ST_WARMUP: begin
                    lane_q    <= adv_d;
                    r_q       <= '0;
                    r_valid_q <= 1'b0;
                    warm_q    <= warm_q + 8'd1;
                    if (warm_q == WARM_LAST) begin
                        state_q <= ST_RUN;
                        busy_q  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (rnd.en) begin
                        lane_q    <= adv_d;
                        r_q       <= adv_d;
                        r_valid_q <= 1'b1;
                        life_q    <= life_q + LIFE_W'(1);
                        // The word delivered here is the last one of this seed.
                        if (&life_q) begin
                            state_q      <= ST_EXHAUST;
                            reseed_req_q <= 1'b1;
                        end
                    end else begin
                        // Zeroing on gaps guarantees a word is never shown twice.
                        r_q       <= '0;
                        r_valid_q <= 1'b0;
                    end
                end
                ST_EXHAUST: begin
                    r_q       <= '0;
                    r_valid_q <= 1'b0;
                end
                default: begin
                    state_q      <= ST_IDLE;
                    r_q          <= '0;
                    r_valid_q    <= 1'b0;
                    busy_q       <= 1'b0;
                    reseed_req_q <= 1'b1;
                end
            endcase
        end
    end

    assign rnd.r          = r_q;
    assign rnd.r_valid    = r_valid_q;
    assign rnd.busy       = busy_q;
    assign rnd.reseed_req = reseed_req_q;

endmodule

// File: tb/tb_midori_rand_supply.sv
// -----------------------------------------------------------------------------
// tb_midori_rand_supply
// Directed bench for midori_rand_supply (WARMUP=16, LIFE_W=3 so that the
// seed lifetime is 8 words). Expected words come from a bit-serial LFSR model.
// -----------------------------------------------------------------------------
module tb_midori_rand_supply;

    localparam logic [63:0] A5 = 64'hA5A5_A5A5_A5A5_A5A5;

    logic clk = 1'b0;
    logic rst;

    int vectors     = 0;
    int miscompares = 0;

    logic [191:0] m;
    logic [191:0] seed_a;
    logic [191:0] seed_b;
    logic [191:0] seed_c;
    int           busy_cnt;
    int           vcnt;

    midori_rand_supply_if #(.RW(192)) bus ();

    midori_rand_supply #(
        .RW     (192),
        .WARMUP (16),
        .LIFE_W (3)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .rnd   (bus)
    );

    always #5 clk = ~clk;

    // Reference: each lane stepped 64 times, one bit per step.
    function automatic logic [191:0] ref_adv(input logic [191:0] v);
        logic [63:0] ln [3];
        logic        nb;
        for (int l = 0; l < 3; l++) ln[l] = v[l*64 +: 64];
        for (int s = 0; s < 64; s++) begin
            for (int l = 0; l < 3; l++) begin
                nb    = ln[l][63] ^ ln[l][62] ^ ln[l][60] ^ ln[l][59];
                ln[l] = {ln[l][62:0], nb};
            end
        end
        return {ln[2], ln[1], ln[0]};
    endfunction

    function automatic logic [191:0] ref_adv_n(input logic [191:0] v, input int n);
        logic [191:0] t;
        t = v;
        for (int k = 0; k < n; k++) t = ref_adv(t);
        return t;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_w(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_i(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst            = 1'b1;
        bus.seed       = '0;
        bus.seed_valid = 1'b0;
        bus.en         = 1'b0;
        step();
        step();
        chk_w("rst_r", bus.r, '0);
        chk_b("rst_r_valid", bus.r_valid, 1'b0);
        chk_b("rst_busy", bus.busy, 1'b0);
        chk_b("rst_reseed_req", bus.reseed_req, 1'b1);
        rst = 1'b0;

        // ---- seed {3,2,1}, en held high through warm-up ----
        seed_a         = {64'd3, 64'd2, 64'd1};
        bus.seed       = seed_a;
        bus.seed_valid = 1'b1;
        bus.en         = 1'b1;
        step();
        bus.seed_valid = 1'b0;
        chk_b("load_busy", bus.busy, 1'b1);
        chk_b("load_r_valid", bus.r_valid, 1'b0);
        chk_w("load_r", bus.r, '0);
        chk_b("load_reseed_req", bus.reseed_req, 1'b0);
        busy_cnt = 1;
        for (int i = 0; i < 40 && bus.busy; i++) begin
            step();
            if (bus.busy) busy_cnt++;
        end
        chk_i("warm_busy_cycles", busy_cnt, 16);
        chk_b("warm_end_r_valid", bus.r_valid, 1'b0);
        m = ref_adv_n(seed_a, 17);
        step();
        chk_b("first_r_valid", bus.r_valid, 1'b1);
        chk_w("first_word", bus.r, m);

        // ---- run to exhaustion: 8 words total for LIFE_W=3 ----
        vcnt = 1;
        for (int i = 0; i < 12; i++) begin
            step();
            if (bus.r_valid) begin
                vcnt++;
                m = ref_adv(m);
                chk_w("run_word", bus.r, m);
            end
        end
        chk_i("exhaust_word_count", vcnt, 8);
        chk_b("exhaust_reseed_req", bus.reseed_req, 1'b1);
        chk_b("exhaust_r_valid", bus.r_valid, 1'b0);
        chk_w("exhaust_r", bus.r, '0);
        chk_b("exhaust_busy", bus.busy, 1'b0);

        // ---- zero seed from EXHAUST, then en gaps 1,0,0,1 ----
        bus.seed       = '0;
        bus.seed_valid = 1'b1;
        bus.en         = 1'b0;
        step();
        bus.seed_valid = 1'b0;
        chk_b("zero_load_busy", bus.busy, 1'b1);
        chk_b("zero_load_reseed_req", bus.reseed_req, 1'b0);
        repeat (16) step();
        chk_b("zero_warm_done_busy", bus.busy, 1'b0);
        chk_b("zero_idle_r_valid", bus.r_valid, 1'b0);
        m = ref_adv_n({A5, A5, A5}, 16);
        bus.en = 1'b1;
        step();
        m = ref_adv(m);
        chk_b("gap_v0", bus.r_valid, 1'b1);
        chk_w("gap_w0", bus.r, m);
        chk_b("zero_r_nonzero", (bus.r != '0), 1'b1);
        bus.en = 1'b0;
        step();
        chk_b("gap_v1", bus.r_valid, 1'b0);
        chk_w("gap_r1", bus.r, '0);
        step();
        chk_b("gap_v2", bus.r_valid, 1'b0);
        chk_w("gap_r2", bus.r, '0);
        bus.en = 1'b1;
        step();
        m = ref_adv(m);
        chk_b("gap_v3", bus.r_valid, 1'b1);
        chk_w("gap_w3", bus.r, m);

        // ---- seed_valid together with en in RUN ----
        seed_b         = {64'h1111_2222_3333_4444, 64'h0, 64'hDEAD_BEEF_0BAD_F00D};
        bus.seed       = seed_b;
        bus.seed_valid = 1'b1;
        bus.en         = 1'b1;
        step();
        bus.seed_valid = 1'b0;
        chk_b("coll_r_valid", bus.r_valid, 1'b0);
        chk_b("coll_busy", bus.busy, 1'b1);
        chk_w("coll_r", bus.r, '0);
        repeat (16) step();
        chk_b("coll_warm_done_busy", bus.busy, 1'b0);
        chk_b("coll_warm_done_r_valid", bus.r_valid, 1'b0);
        m = ref_adv_n({seed_b[191:128], A5, seed_b[63:0]}, 16);
        vcnt = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (bus.r_valid) begin
                vcnt++;
                m = ref_adv(m);
                chk_w("coll_word", bus.r, m);
            end
        end
        chk_i("coll_word_count", vcnt, 8);
        chk_b("coll_exhaust_reseed_req", bus.reseed_req, 1'b1);

        // ---- reload in the middle of warm-up restarts it ----
        bus.seed       = seed_a;
        bus.seed_valid = 1'b1;
        step();
        bus.seed_valid = 1'b0;
        repeat (5) step();
        seed_c         = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 64'h8000_0000_0000_0000};
        bus.seed       = seed_c;
        bus.seed_valid = 1'b1;
        step();
        bus.seed_valid = 1'b0;
        busy_cnt = 1;
        for (int i = 0; i < 40 && bus.busy; i++) begin
            step();
            if (bus.busy) busy_cnt++;
        end
        chk_i("rewarm_busy_cycles", busy_cnt, 16);
        step();
        chk_b("rewarm_r_valid", bus.r_valid, 1'b1);
        chk_w("rewarm_word", bus.r, ref_adv_n(seed_c, 17));

        // ---- reset for 2 cycles mid-RUN with en high ----
        rst = 1'b1;
        step();
        chk_w("midrst_r", bus.r, '0);
        chk_b("midrst_r_valid", bus.r_valid, 1'b0);
        chk_b("midrst_busy", bus.busy, 1'b0);
        chk_b("midrst_reseed_req", bus.reseed_req, 1'b1);
        step();
        rst = 1'b0;
        step();
        step();
        chk_b("postrst_r_valid", bus.r_valid, 1'b0);
        chk_w("postrst_r", bus.r, '0);
        chk_b("postrst_reseed_req", bus.reseed_req, 1'b1);
        chk_b("postrst_busy", bus.busy, 1'b0);

        // ---- rst together with seed_valid ----
        bus.seed       = seed_a;
        bus.seed_valid = 1'b1;
        step();
        chk_b("pre_rstcoll_busy", bus.busy, 1'b1);
        rst = 1'b1;
        step();
        chk_b("rstcoll_busy", bus.busy, 1'b0);
        chk_b("rstcoll_reseed_req", bus.reseed_req, 1'b1);
        rst            = 1'b0;
        bus.seed_valid = 1'b0;
        step();
        chk_b("rstcoll_idle_busy", bus.busy, 1'b0);
        chk_b("rstcoll_idle_r_valid", bus.r_valid, 1'b0);
        chk_b("rstcoll_idle_reseed_req", bus.reseed_req, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
